display_scroller: RTL and testbench
===================================

# display_scroller

Downstream consumer of the character encryption stage. Accepts encrypted ASCII characters over a valid/ready handshake and stores them in a message buffer. Drives a multiplexed, common-anode, active-low 7-segment display. Messages of up to DIGITS characters are shown static; longer messages scroll left, wrapping around.

## Interface
Parameters:
- DIGITS, 4: number of physical display digits (2–8).
- BUF_DEPTH, 16: message buffer capacity in characters (power of two, ≥ DIGITS+1).
- REFRESH_DIV, 50000: clocks per digit slot of the multiplex scan.
- SCROLL_DIV, 25000000: clocks per one-position scroll step.

Ports:
- clk  in  1  single system clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- char_in  in  8  ASCII character from the encryption stage.
- char_valid  in  1  char_in is valid this cycle.
- char_ready  out  1  buffer can accept a character this cycle.
- clear  in  1  synchronous pulse; empties the buffer.
- seg_n  out  7  segment drive {g,f,e,d,c,b,a}, active-low.
- an_n  out  DIGITS  digit enables, active-low, one-hot; bit 0 is the leftmost digit.
- count  out  $clog2(BUF_DEPTH+1)  number of stored characters.

## Operation
- Write: when char_valid && char_ready, char_in is stored at buf[count], and count increments on the same edge.
- char_ready = (count != BUF_DEPTH) && !clear. This is combinational from registers and clear only, never from char_valid.
- clear takes priority over a write in the same cycle. count ← 0, window pointer wp ← 0, and the state goes to EMPTY.
- State machine:
  - EMPTY (count == 0): all digits blank.
  - STATIC (1 ≤ count ≤ DIGITS): digit i shows buf[i] for i < count. Digits i ≥ count are blank.
  - SCROLL (count > DIGITS): digit i shows stream[(wp+i) mod L].
- Transitions follow count. A STATIC→SCROLL transition resets wp to 0 and restarts the scroll counter.
- Scroll: a 32-bit-safe counter counts 0..SCROLL_DIV-1, but only in SCROLL. On the terminal count, wp ← (wp+1 == L) ? 0 : wp+1.
- Writes during SCROLL increase L but do not move wp.
- Scan: a digit index counts 0..DIGITS-1 and advances every REFRESH_DIV clocks. It runs in all states. an_n = ~(1 << idx).
- Decode: seg_n = glyph(shown character):
  - '0'–'9' use standard digit glyphs.
  - 'A'–'Z' and 'a'–'z' share one case-folded glyph set.
  - Any other code, or a blank, gives 7'b1111111.
- Reset values: count 0, wp 0, state EMPTY, idx 0, both counters 0, seg_n 7'b1111111, an_n all ones.
  - an_n stays all ones until the first digit slot after reset release.
  - Reset mid-scroll discards the buffer contents.

## Timing
- A write is accepted on the edge where char_valid && char_ready. char_ready may fall on the very next cycle when the buffer becomes full.
- seg_n and an_n are registered and update together, one cycle after idx changes, so there is no ghosting between digits.
- A newly written character appears no later than the next scan slot of its digit.
- A clear blanks the display within one clock.

## Configuration
- SCROLL_GAP_EN:
  - Defined: the scroll stream is the message followed by DIGITS blank positions, so L = count + DIGITS. The message fully exits the display before it re-enters from the right.
  - Undefined: L = count, and the message wraps seamlessly with the last character adjacent to the first.
  - STATIC and EMPTY behaviour is identical either way.

## Structure
- Shared package display_pkg holds:
  - segment glyph constants (SEG_BLANK, SEG_0 … SEG_9, SEG_A … SEG_Z);
  - the display state enum {EMPTY, STATIC, SCROLL}.
- One sub-module, ascii_to_seg: a combinational mapping from 8-bit ASCII to the 7-bit active-low glyph.
- Buffer, FSM, counters and scan logic live in display_scroller.

## Test plan
Bench parameters: DIGITS=4, BUF_DEPTH=8, REFRESH_DIV=4, SCROLL_DIV=32.
- Reset, then observe for 20 clocks:
  - count=0 and char_ready=1.
  - an_n cycles 1110→1101→1011→0111 every 4 clocks.
  - seg_n stays 1111111.
- Write "0A" back-to-back, then scan:
  - Digit 0 shows seg_n 1000000 and digit 1 shows 0001000.
  - Digits 2–3 show 1111111.
  - count=2.
- Write 8 characters "HELLO123" with char_valid held high, offering a 9th:
  - char_ready drops after the 8th write, and the 9th is not stored.
  - count=8.
  - The display starts at "HELL" and shifts to "ELLO" 32 clocks later.
- Same as the previous scenario, without SCROLL_GAP_EN: after 8 steps the window returns to "HELL", and at wp=6 it shows "23HE".
- Same as the previous scenario, with SCROLL_GAP_EN: at wp=6 the window shows "23", then two blanks; "HELL" reappears at wp=12→0.
- Edge cases:
  - clear and a valid write in the same cycle: count=0, the character is dropped, and the display is blank by the next slot.
  - rst asserted mid-scroll: seg_n and an_n go to all ones immediately.

Source files
------------

// File: rtl/display_pkg.sv
// Shared glyph constants and display state enum for the display scroller.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package display_pkg;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0 = 7'b1000000, SEG_1 = 7'b1111001, SEG_2 = 7'b0100100,
                           SEG_3 = 7'b0110000, SEG_4 = 7'b0011001, SEG_5 = 7'b0010010,
                           SEG_6 = 7'b0000010, SEG_7 = 7'b1111000, SEG_8 = 7'b0000000,
                           SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000, SEG_B = 7'b0000011, SEG_C = 7'b1000110,
                           SEG_D = 7'b0100001, SEG_E = 7'b0000110, SEG_F = 7'b0001110,
                           SEG_G = 7'b1000010, SEG_H = 7'b0001001, SEG_I = 7'b1001111,
                           SEG_J = 7'b1100001, SEG_K = 7'b0001010, SEG_L = 7'b1000111,
                           SEG_M = 7'b1101010, SEG_N = 7'b0101011, SEG_O = 7'b0100011,
                           SEG_P = 7'b0001100, SEG_Q = 7'b0011000, SEG_R = 7'b0101111,
                           SEG_S = 7'b0010010, SEG_T = 7'b0000111, SEG_U = 7'b1000001,
                           SEG_V = 7'b1100011, SEG_W = 7'b1010101, SEG_X = 7'b0001011,
                           SEG_Y = 7'b0010001, SEG_Z = 7'b0100100;

    typedef enum logic [1:0] {EMPTY, STATIC, SCROLL} disp_state_e;
endpackage

// File: rtl/display_scroller_if.sv
// Character handshake from the encryption stage into the display scroller.
interface display_scroller_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (output char_in, output char_valid, input char_ready);
    modport slave  (input char_in, input char_valid, output char_ready);
endinterface

// File: rtl/ascii_to_seg.sv
// Combinational ASCII to active-low 7-segment glyph; letters are case-folded.
module ascii_to_seg
    import display_pkg::*;
(
    input  logic [7:0] ch_i,
    output logic [6:0] seg_o
);
    logic [7:0] up;

    always_comb begin
        up = ch_i;
        if (ch_i >= "a" && ch_i <= "z") up = ch_i - 8'd32;
        seg_o = SEG_BLANK;
        case (up)
            "0": seg_o = SEG_0;  "1": seg_o = SEG_1;  "2": seg_o = SEG_2;
            "3": seg_o = SEG_3;  "4": seg_o = SEG_4;  "5": seg_o = SEG_5;
            "6": seg_o = SEG_6;  "7": seg_o = SEG_7;  "8": seg_o = SEG_8;
            "9": seg_o = SEG_9;
            "A": seg_o = SEG_A;  "B": seg_o = SEG_B;  "C": seg_o = SEG_C;
            "D": seg_o = SEG_D;  "E": seg_o = SEG_E;  "F": seg_o = SEG_F;
            "G": seg_o = SEG_G;  "H": seg_o = SEG_H;  "I": seg_o = SEG_I;
            "J": seg_o = SEG_J;  "K": seg_o = SEG_K;  "L": seg_o = SEG_L;
            "M": seg_o = SEG_M;  "N": seg_o = SEG_N;  "O": seg_o = SEG_O;
            "P": seg_o = SEG_P;  "Q": seg_o = SEG_Q;  "R": seg_o = SEG_R;
            "S": seg_o = SEG_S;  "T": seg_o = SEG_T;  "U": seg_o = SEG_U;
            "V": seg_o = SEG_V;  "W": seg_o = SEG_W;  "X": seg_o = SEG_X;
            "Y": seg_o = SEG_Y;  "Z": seg_o = SEG_Z;
            default: seg_o = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/display_scroller.sv
// Message buffer, static/scroll FSM and multiplexed 7-segment scan.
// SCROLL_GAP_EN appends DIGITS blank positions to the scroll stream.
module display_scroller
    import display_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int BUF_DEPTH   = 16,
    parameter int REFRESH_DIV = 50000,
    parameter int SCROLL_DIV  = 25000000
) (
    input  logic                           clk,
    input  logic                           rst,
    display_scroller_if.slave              ch,
    input  logic                           clear,
    output logic [6:0]                     seg_n,
    output logic [DIGITS-1:0]              an_n,
    output logic [$clog2(BUF_DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int IW = $clog2(DIGITS);
    localparam int WW = $clog2(BUF_DEPTH + DIGITS + 1);
`ifdef SCROLL_GAP_EN
    localparam int GAP = DIGITS;
`else
    localparam int GAP = 0;
`endif

    logic [7:0]        buf_q [BUF_DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic [WW-1:0]     wp_q, wp_d, len;
    logic [31:0]       scnt_q, scnt_d, rcnt_q, rcnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        seg_q, seg_d, glyph;
    logic [DIGITS-1:0] an_q, an_d;
    disp_state_e       state_q, state_d;
    logic [WW:0]       pos;
    logic [7:0]        shown;
    logic              wr;

    assign ch.char_ready = (count_q != CW'(BUF_DEPTH)) && !clear;
    assign wr    = ch.char_valid && ch.char_ready;
    assign len   = WW'(count_q) + WW'(GAP);
    assign count = count_q;
    assign seg_n = seg_q;
    assign an_n  = an_q;

    always_ff @(posedge clk) begin
        if (wr) buf_q[count_q[AW-1:0]] <= ch.char_in;
    end

    always_comb begin
        count_d = count_q;
        if (clear)   count_d = '0;
        else if (wr) count_d = count_q + 1'b1;

        if (count_d == '0)                state_d = EMPTY;
        else if (count_d <= CW'(DIGITS))  state_d = STATIC;
        else                              state_d = SCROLL;

        wp_d   = wp_q;
        scnt_d = scnt_q;
        if (state_d == SCROLL && state_q != SCROLL) begin
            wp_d   = '0;
            scnt_d = '0;
        end else if (state_q == SCROLL) begin
            if (scnt_q == 32'(SCROLL_DIV - 1)) begin
                scnt_d = '0;
                wp_d   = (wp_q + 1'b1 == len) ? '0 : wp_q + 1'b1;
            end else begin
                scnt_d = scnt_q + 32'd1;
            end
        end
        if (clear) begin
            wp_d   = '0;
            scnt_d = '0;
        end

        rcnt_d = rcnt_q + 32'd1;
        idx_d  = idx_q;
        if (rcnt_q == 32'(REFRESH_DIV - 1)) begin
            rcnt_d = '0;
            idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Window position wraps at most once since wp < L and idx < DIGITS <= L.
    always_comb begin
        pos = (WW+1)'(wp_q) + (WW+1)'(idx_q);
        if (pos >= {1'b0, len}) pos = pos - {1'b0, len};
        shown = 8'h00;
        case (state_q)
            STATIC:  if (CW'(idx_q) < count_q) shown = buf_q[AW'(idx_q)];
            SCROLL:  if (pos < (WW+1)'(count_q)) shown = buf_q[pos[AW-1:0]];
            default: shown = 8'h00;
        endcase
        seg_d = clear ? SEG_BLANK : glyph;
        an_d  = ~(DIGITS'(1) << idx_q);
    end

    ascii_to_seg u_dec (.ch_i(shown), .seg_o(glyph));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wp_q    <= '0;
            state_q <= EMPTY;
            scnt_q  <= '0;
            rcnt_q  <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= '1;
        end else begin
            count_q <= count_d;
            wp_q    <= wp_d;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            rcnt_q  <= rcnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end
endmodule

// File: tb/tb_display_scroller.sv
// Directed bench for display_scroller; accepted characters are queued in a
// message model that expectations are drawn from.
module tb_display_scroller;
    localparam int DIGITS = 4, BUF_DEPTH = 8, REFRESH_DIV = 4, SCROLL_DIV = 32;

    logic       clk = 1'b0, rst = 1'b1, clear = 1'b0;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic [3:0] count;

    display_scroller_if ch();

    display_scroller #(.DIGITS(DIGITS), .BUF_DEPTH(BUF_DEPTH),
                       .REFRESH_DIV(REFRESH_DIV), .SCROLL_DIV(SCROLL_DIV)) dut (
        .clk(clk), .rst(rst), .ch(ch), .clear(clear),
        .seg_n(seg_n), .an_n(an_n), .count(count));

    always #5 clk = ~clk;

    int ecnt;
    always @(posedge clk or posedge rst)
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;

    int  checks = 0, failures = 0;
    int  t_scroll = 0;
    byte msg_q[$];

    function automatic logic [6:0] glyph(byte c);
        case (c)
            "0":      return 7'b1000000;
            "1":      return 7'b1111001;
            "2":      return 7'b0100100;
            "3":      return 7'b0110000;
            "A", "a": return 7'b0001000;
            "E", "e": return 7'b0000110;
            "H", "h": return 7'b0001001;
            "L", "l": return 7'b1000111;
            "O", "o": return 7'b0100011;
            default:  return 7'b1111111;
        endcase
    endfunction

    // Scan position visible after edge n: outputs lag the digit index by one clock.
    function automatic int dig(int n);
        return ((n - 1) / REFRESH_DIV) % DIGITS;
    endfunction

    function automatic logic [3:0] an_exp(int n);
        if (n == 0) return 4'b1111;
        return ~(4'b0001 << dig(n));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_win(input string tag, input string w, input int ncyc);
        int n;
        repeat (ncyc) begin
            @(negedge clk);
            n = ecnt;
            chk({tag, ".an"}, 32'(an_n), 32'(an_exp(n)));
            if (n == 0) chk({tag, ".seg"}, 32'(seg_n), 32'h7f);
            else        chk({tag, ".seg"}, 32'(seg_n), 32'(glyph(w[dig(n)])));
        end
    endtask

    task automatic put(input byte c);
        logic exp_rdy;
        @(negedge clk);
        ch.char_in    = c;
        ch.char_valid = 1'b1;
        #1;
        exp_rdy = (msg_q.size() != BUF_DEPTH);
        chk("ready", 32'(ch.char_ready), 32'(exp_rdy));
        if (exp_rdy) begin
            msg_q.push_back(c);
            if (msg_q.size() == DIGITS + 1) t_scroll = ecnt + 1;
        end
    endtask

    task automatic stop_wr();
        @(negedge clk);
        ch.char_valid = 1'b0;
    endtask

    task automatic step(input string tag, input int k, input string w);
        int g = 0;
        while ((ecnt - 1 - t_scroll) < SCROLL_DIV * k && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) chk({tag, ".timeout"}, 32'd1, 32'd0);
        check_win(tag, w, 16);
    endtask

    initial begin
        string s;
        ch.char_in = 8'h00;
        ch.char_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.seg", 32'(seg_n), 32'h7f);
        chk("rst.an", 32'(an_n), 32'hf);
        rst = 1'b0;
        #1;
        chk("rel.an", 32'(an_n), 32'hf);
        chk("rel.count", 32'(count), 32'd0);
        chk("rel.ready", 32'(ch.char_ready), 32'd1);
        check_win("idle", "    ", 20);
        chk("idle.count", 32'(count), 32'd0);

        put("0"); put("A"); stop_wr();
        check_win("st2", "0A  ", 16);
        chk("st2.count", 32'(count), 32'(msg_q.size()));
        put("-"); put("h"); stop_wr();
        check_win("st4", "0A H", 16);
        chk("st4.count", 32'(count), 32'(msg_q.size()));

        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        msg_q.delete();
        chk("clr.count", 32'(count), 32'd0);

        s = "HELLO123X";
        for (int i = 0; i < 9; i++) put(s[i]);
        stop_wr();
        chk("full.count", 32'(count), 32'(msg_q.size()));
        chk("full.ready", 32'(ch.char_ready), 32'd0);
        step("wp0", 0, "HELL");
        step("wp1", 1, "ELLO");
`ifdef SCROLL_GAP_EN
        step("wp6", 6, "23  ");
        step("wp7", 7, "3   ");
        step("wp8", 8, "    ");
        step("wrap", 12, "HELL");
`else
        step("wp6", 6, "23HE");
        step("wp7", 7, "3HEL");
        step("wrap", 8, "HELL");
        step("wp4", 12, "O123");
`endif

        @(negedge clk);
        clear = 1'b1; ch.char_valid = 1'b1; ch.char_in = "Z";
        #1;
        chk("clrwr.ready", 32'(ch.char_ready), 32'd0);
        @(negedge clk);
        clear = 1'b0; ch.char_valid = 1'b0;
        msg_q.delete();
        chk("clrwr.count", 32'(count), 32'd0);
        chk("clrwr.seg", 32'(seg_n), 32'h7f);
        check_win("clrwr", "    ", 16);
        chk("clrwr.count2", 32'(count), 32'd0);

        s = "ABCDEF";
        for (int i = 0; i < 6; i++) put(s[i]);
        stop_wr();
        chk("scr.count", 32'(count), 32'd6);
        repeat (40) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst.seg", 32'(seg_n), 32'h7f);
        chk("midrst.an", 32'(an_n), 32'hf);
        chk("midrst.count", 32'(count), 32'd0);
        @(negedge clk) rst = 1'b0;
        msg_q.delete();
        check_win("postrst", "    ", 8);
        chk("postrst.count", 32'(count), 32'd0);
        chk("postrst.ready", 32'(ch.char_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
